logic_basic_queue_controller: RTL and testbench

LOGIC_BASIC_QUEUE_CONTROLLER -- requirements
Module: logic_basic_queue_controller

---
 rtl/logic_basic_queue_pkg.sv | 21 ++
 rtl/logic_basic_queue_controller.sv | 134 +++++++++++++
 tb/tb_logic_basic_queue_controller.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_basic_queue_pkg.sv
// logic_basic_queue_pkg: width helpers and default-configuration types shared
// by the queue controller and the code that pairs it with its memory.
package logic_basic_queue_pkg;

  // Pointer width for a memory of 'capacity' entries (never below 1 bit).
  function automatic int addr_width(input int capacity);
    return (capacity > 1) ? $clog2(capacity) : 1;
  endfunction

  // Width needed to hold any count from 0 up to and including 'max_count'.
  function automatic int count_width(input int max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

  // Types for the default four-entry configuration.
  localparam int DEFAULT_CAPACITY = 4;
  typedef logic [addr_width(DEFAULT_CAPACITY)-1:0]      ptr_t;
  typedef logic [count_width(DEFAULT_CAPACITY)-1:0]     count_t;
  typedef logic [count_width(DEFAULT_CAPACITY + 1)-1:0] level_t;

endpackage

// File: rtl/logic_basic_queue_controller.sv
// logic_basic_queue_controller: queue control for an external synchronous
// memory (logic_basic_queue_generic_memory) plus a one-word output stage
// formed by the memory's read register. Holds CAPACITY+1 words in total.
//
// Optional feature: define LOGIC_BASIC_QUEUE_CONTROLLER_ALMOST_FLAGS_EN to get
// registered almost_full / almost_empty flags; otherwise both are tied to 0.
//
// Handshake rule (both sides): a word moves on a rising aclk edge exactly when
// tvalid and tready are both high; tvalid, once high, holds with stable tdata
// until that transfer; tready may change freely and never depends on tvalid.
module logic_basic_queue_controller
  import logic_basic_queue_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int CAPACITY     = 4,
  parameter int ALMOST_FULL  = CAPACITY - 1,
  parameter int ALMOST_EMPTY = 1,
  localparam int AW = addr_width(CAPACITY),
  localparam int LW = count_width(CAPACITY + 1)
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  input  logic [DATA_WIDTH-1:0] rx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic [DATA_WIDTH-1:0] tx_tdata,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [AW-1:0]         write_pointer,
  output logic                  read_enable,
  output logic [AW-1:0]         read_pointer,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CW = count_width(CAPACITY);
  localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

  // Reject configurations the pointer arithmetic cannot support.
  if (CAPACITY < 2 || (CAPACITY & (CAPACITY - 1)) != 0 ||
      ALMOST_FULL < 0 || ALMOST_FULL > CAPACITY + 1 ||
      ALMOST_EMPTY < 0 || ALMOST_EMPTY > CAPACITY + 1) begin : g_bad_params
    $error("logic_basic_queue_controller: unsupported CAPACITY/threshold parameters");
  end

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] mem_count;
  logic [CW-1:0] mem_count_nxt;
  logic          tx_tvalid_nxt;
  logic [LW-1:0] level_nxt;
  logic          wr_fire;
  logic          rd_fire;

  // Memory is only read when it holds data and the output register is free or
  // being emptied this cycle. Since mem_count counts words already written,
  // a read never targets the slot being written in the same cycle. Both
  // strobes are gated by reset so the memory port is idle while it is held.
  assign wr_fire = areset_n & rx_tvalid & rx_tready;
  assign rd_fire = areset_n & (mem_count != '0) & (~tx_tvalid | tx_tready);

  assign write_enable  = wr_fire;
  assign write_data    = rx_tdata;
  assign write_pointer = wp;
  assign read_enable   = rd_fire;
  assign read_pointer  = rp;
  // The memory's read register is the output stage: it holds while no read
  // is issued, so tx_tdata stays stable throughout a stall.
  assign tx_tdata      = read_data;

  // Next-state values for the occupancy counters and output-stage valid.
  always_comb begin
    mem_count_nxt = mem_count;
    case ({wr_fire, rd_fire})
      2'b10:   mem_count_nxt = mem_count + CW'(1);
      2'b01:   mem_count_nxt = mem_count - CW'(1);
      default: mem_count_nxt = mem_count;
    endcase
    tx_tvalid_nxt = tx_tvalid;
    if (rd_fire) begin
      tx_tvalid_nxt = 1'b1;
    end else if (tx_tvalid && tx_tready) begin
      tx_tvalid_nxt = 1'b0;
    end
    level_nxt = LW'(mem_count_nxt) + LW'(tx_tvalid_nxt);
  end

  // Pointers, counts, output valid and registered write-side ready.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wp        <= '0;
      rp        <= '0;
      mem_count <= '0;
      tx_tvalid <= 1'b0;
      rx_tready <= 1'b0;
      level     <= '0;
    end else begin
      if (wr_fire) begin
        wp <= wp + AW'(1);
      end
      if (rd_fire) begin
        rp <= rp + AW'(1);
      end
      mem_count <= mem_count_nxt;
      tx_tvalid <= tx_tvalid_nxt;
      rx_tready <= (mem_count_nxt < CAP_C);
      level     <= level_nxt;
    end
  end

`ifdef LOGIC_BASIC_QUEUE_CONTROLLER_ALMOST_FLAGS_EN
  localparam logic [LW-1:0] AF_C = LW'(ALMOST_FULL);
  localparam logic [LW-1:0] AE_C = LW'(ALMOST_EMPTY);

  // Threshold flags track the same next level that loads the level register.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_nxt >= AF_C);
      almost_empty <= (level_nxt <= AE_C);
    end
  end
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_logic_basic_queue_controller.sv
// tb_logic_basic_queue_controller: directed and randomized checks of the queue
// controller paired with a behavioural synchronous memory.
module tb_logic_basic_queue_controller;

  localparam int DW  = 8;
  localparam int CAP = 4;
  localparam int AF  = 4;
  localparam int AE  = 1;
  localparam int AW  = 2;
  localparam int LW  = 3;

  // ---------------- clock / reset ----------------
  logic aclk     = 1'b0;
  logic areset_n = 1'b0;
  always #5 aclk = ~aclk;

  logic          rx_tvalid;
  logic          rx_tready;
  logic [DW-1:0] rx_tdata;
  logic          tx_tvalid;
  logic          tx_tready;
  logic [DW-1:0] tx_tdata;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_pointer;
  logic          read_enable;
  logic [AW-1:0] read_pointer;
  logic [DW-1:0] read_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  logic_basic_queue_controller #(
    .DATA_WIDTH  (DW),
    .CAPACITY    (CAP),
    .ALMOST_FULL (AF),
    .ALMOST_EMPTY(AE)
  ) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .rx_tvalid    (rx_tvalid),
    .rx_tready    (rx_tready),
    .rx_tdata     (rx_tdata),
    .tx_tvalid    (tx_tvalid),
    .tx_tready    (tx_tready),
    .tx_tdata     (tx_tdata),
    .write_enable (write_enable),
    .write_data   (write_data),
    .write_pointer(write_pointer),
    .read_enable  (read_enable),
    .read_pointer (read_pointer),
    .read_data    (read_data),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  // Synchronous memory: registered read, output holds while not reading.
  logic [DW-1:0] mem_model [CAP];
  logic [DW-1:0] rd_reg;
  always @(posedge aclk) begin
    if (write_enable) mem_model[write_pointer] <= write_data;
    if (read_enable)  rd_reg <= mem_model[read_pointer];
  end
  assign read_data = rd_reg;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_del    = 0;
  int wait_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags(input int lvl);
`ifdef LOGIC_BASIC_QUEUE_CONTROLLER_ALMOST_FLAGS_EN
    check_eq("almost_full", almost_full, (lvl >= AF));
    check_eq("almost_empty", almost_empty, (lvl <= AE));
`else
    check_eq("almost_full_tied", almost_full, 0);
    check_eq("almost_empty_tied", almost_empty, 0);
`endif
  endtask

  // Occupancy is accepted-minus-delivered; the queue refuses only when all
  // CAPACITY+1 places are taken; a held word must not change.
  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check_eq("level", level, sz);
    check_eq("rx_tready", rx_tready, (sz < CAP + 1));
    check_flags(sz);
    if (prev_stall) begin
      check_eq("stall_valid", tx_tvalid, 1);
      check_eq("stall_data", tx_tdata, prev_data);
    end
    if (sz > 0 && !tx_tvalid) begin
      wait_cnt++;
      check_eq("tx_valid_latency", (wait_cnt > 1), 0);
    end else begin
      wait_cnt = 0;
    end
    if (sz == 0) check_eq("tx_valid_empty", tx_tvalid, 0);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: check state left by the last edge, drive inputs for the next
  // edge, and account for the transfers that edge will perform.
  task automatic tick(input logic vld, input logic [DW-1:0] d, input logic rdy);
    @(negedge aclk);
    check_state();
    rx_tvalid = vld;
    rx_tdata  = d;
    tx_tready = rdy;
    if (tx_tvalid && rdy) begin
      if (exp_q.size() == 0) begin
        check_eq("tx_unexpected", tx_tvalid, 0);
      end else begin
        check_eq("tx_data", tx_tdata, exp_q.pop_front());
        n_del++;
      end
    end
    if (vld && rx_tready) begin
      exp_q.push_back(d);
      n_acc++;
    end
    prev_stall = tx_tvalid && !rdy;
    prev_data  = tx_tdata;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge aclk);
    areset_n  = 1'b0;
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    repeat (cycles) @(negedge aclk);
    check_eq("rst_tx_tvalid", tx_tvalid, 0);
    check_eq("rst_rx_tready", rx_tready, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_write_enable", write_enable, 0);
    check_eq("rst_read_enable", read_enable, 0);
    check_eq("rst_almost_full", almost_full, 0);
`ifdef LOGIC_BASIC_QUEUE_CONTROLLER_ALMOST_FLAGS_EN
    check_eq("rst_almost_empty", almost_empty, 1);
`else
    check_eq("rst_almost_empty", almost_empty, 0);
`endif
    exp_q.delete();
    prev_stall = 1'b0;
    wait_cnt   = 0;
    areset_n   = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    int d0;
    int cycles;
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
    tx_tready = 1'b0;

    apply_reset(3);

    // Single word into an empty queue: visible two cycles after acceptance.
    tick(1'b1, 8'h01, 1'b1);
    #1;
    check_eq("write_enable", write_enable, 1);
    check_eq("write_pointer", write_pointer, 0);
    check_eq("write_data", write_data, 8'h01);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("latency_c1_valid", tx_tvalid, 0);
    check_eq("latency_c1_read_enable", read_enable, 1);
    check_eq("latency_c1_read_pointer", read_pointer, 0);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("latency_c2_valid", tx_tvalid, 1);
    check_eq("latency_c2_data", tx_tdata, 8'h01);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("drained_level", level, 0);

    // Fill with output stalled: five words fit, the sixth is refused.
    for (int i = 0; i < 5; i++) tick(1'b1, DW'(8'h10 + i), 1'b0);
    tick(1'b1, 8'hEE, 1'b0);
    check_eq("full_ready", rx_tready, 0);
    check_eq("full_level", level, 5);
    tick(1'b1, 8'hEF, 1'b0);
    tick(1'b1, 8'hF0, 1'b0);

    // Release from full with both sides active for 20 cycles. Ready is
    // registered, so the first cycle only drains; every later cycle moves a
    // word in each direction.
    a0 = n_acc;
    d0 = n_del;
    for (int i = 0; i < 20; i++) tick(1'b1, DW'(8'h40 + i), 1'b1);
    check_eq("stream_delivered", n_del - d0, 20);
    check_eq("stream_accepted", n_acc - a0, 19);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("stream_level", level, 4);

    // Random traffic with random output stalls until 1000 words delivered.
    d0 = n_del;
    cycles = 0;
    while ((n_del - d0) < 1000 && cycles < 20000) begin
      tick(($urandom_range(0, 99) < 70), DW'($urandom), ($urandom_range(0, 99) < 60));
      cycles++;
    end
    check_eq("random_1000_words", ((n_del - d0) >= 1000), 1);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      tick(1'b0, 8'h00, 1'b1);
      cycles++;
    end
    tick(1'b0, 8'h00, 1'b1);
    check_eq("random_drain_level", level, 0);

    // Reset mid-operation with three words held.
    for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'hA0 + i), 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("pre_reset_level", level, 3);
    apply_reset(1);
    tick(1'b0, 8'h00, 1'b0);
    check_eq("post_reset_ready", rx_tready, 1);
    tick(1'b1, 8'h5A, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    check_eq("post_reset_valid", tx_tvalid, 1);
    check_eq("post_reset_word", tx_tdata, 8'h5A);
    for (int i = 0; i < 40; i++) begin
      tick(($urandom_range(0, 99) < 50), DW'($urandom), ($urandom_range(0, 99) < 50));
    end
    tick(1'b0, 8'h00, 1'b1);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
